// File: rtl/rr_shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// FSM state encoding and a constant-foldable ceil(log2) helper.
package rr_shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_ROTATE = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_shared_reg_arbiter_pick.sv
// Rotating-priority encoder: picks the first asserted request at or after
// ptr_i (wrapping modulo N_REQ). Purely combinational.
module rr_shared_reg_arbiter_pick
  import rr_shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Scan candidates ptr, ptr+1, ... and latch onto the first requester seen.
  always_comb begin
    sum_s    = '0;
    cand_s   = '0;
    found_s  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(N_REQ)) begin
        sum_s = sum_s - (IW+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!found_s && req_i[cand_s]) begin
        found_s          = 1'b1;
        onehot_o[cand_s] = 1'b1;
        idx_o            = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter sharing one DW-bit register among N_REQ requesters.
// Optional feature: define RR_BURST_LIMIT_EN to cap each grant at MAX_BURST loads.
module rr_shared_reg_arbiter
  import rr_shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] data_in,
  output logic [N_REQ-1:0]  grant,
  output logic              busy,
  output logic [DW-1:0]     q,
  output logic              q_valid
);

  localparam int IW = clog2(N_REQ);

  if (N_REQ < 2 || DW < 1 || MAX_BURST < 1) begin : g_param_check
    $error("rr_shared_reg_arbiter: N_REQ must be >= 2, DW and MAX_BURST >= 1");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             q_valid_q, q_valid_d;
  logic             busy_q;
  logic             release_s;

  logic [N_REQ-1:0] pick_onehot_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic [DW-1:0]    data_arr_s [N_REQ];

`ifdef RR_BURST_LIMIT_EN
  localparam int BW = clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_q, burst_d;
`endif

  for (genvar k = 0; k < N_REQ; k++) begin : g_data_split
    assign data_arr_s[k] = data_in[k*DW +: DW];
  end

  rr_shared_reg_arbiter_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // The counter saturates at MAX_BURST because release fires before it can go further.
`ifdef RR_BURST_LIMIT_EN
  assign release_s = !req[idx_q] || (burst_q == BW'(MAX_BURST));
`else
  assign release_s = !req[idx_q];
`endif

  // Next-state and datapath decisions; q_valid defaults low so it only follows a load.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    q_valid_d = 1'b0;
`ifdef RR_BURST_LIMIT_EN
    burst_d   = burst_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_d = pick_onehot_s;
          idx_d   = pick_idx_s;
          state_d = ST_OWN;
`ifdef RR_BURST_LIMIT_EN
          burst_d = '0;
`endif
        end else begin
          grant_d = '0;
        end
      end
      ST_OWN: begin
        if (release_s) begin
          grant_d = '0;
          state_d = ST_ROTATE;
        end else begin
          data_d    = data_arr_s[idx_q];
          q_valid_d = 1'b1;
`ifdef RR_BURST_LIMIT_EN
          burst_d   = burst_q + BW'(1);
`endif
        end
      end
      ST_ROTATE: begin
        grant_d = '0;
        state_d = ST_IDLE;
        if (idx_q == IW'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = idx_q + IW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, grant and shared register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      q_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RR_BURST_LIMIT_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      q_valid_q <= q_valid_d;
      busy_q    <= (state_d != ST_IDLE);
`ifdef RR_BURST_LIMIT_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign q       = data_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Directed, table-driven bench for rr_shared_reg_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Burst-limit expectations follow RR_BURST_LIMIT_EN.
module tb_rr_shared_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  q;
  logic        q_valid;

  int checks;
  int errors;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  q;
    logic        qv;
    logic        busy;
  } vec_t;

  localparam int NV = 30;
  vec_t vec [NV];

  rr_shared_reg_arbiter #(
    .N_REQ     (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .busy    (busy),
    .q       (q),
    .q_valid (q_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g,
                              input logic [7:0] qq, input logic v, input logic b);
    vec_t t;
    t.req = r; t.data = d; t.grant = g; t.q = qq; t.qv = v; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    logic [7:0] bytes [4];
    int e, slot, pos;

    checks = 0;
    errors = 0;

    // req, data, expected grant, q, q_valid, busy after the following edge
    vec[0]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    vec[1]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    vec[2]  = mk(4'b0100, 32'h00A5_0000, 4'b0100, 8'h00, 1'b0, 1'b1);
    vec[3]  = mk(4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 1'b1, 1'b1);
    vec[4]  = mk(4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 1'b1, 1'b1);
    vec[5]  = mk(4'b0100, 32'h003C_0000, 4'b0100, 8'h3C, 1'b1, 1'b1);
    vec[6]  = mk(4'b0100, 32'h003C_0000, 4'b0100, 8'h3C, 1'b1, 1'b1);
    vec[7]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h3C, 1'b0, 1'b1);
    vec[8]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h3C, 1'b0, 1'b0);
    vec[9]  = mk(4'b1001, 32'h1100_0022, 4'b1000, 8'h3C, 1'b0, 1'b1);
    vec[10] = mk(4'b1001, 32'h1100_0022, 4'b1000, 8'h11, 1'b1, 1'b1);
    vec[11] = mk(4'b0001, 32'h1100_0022, 4'b0000, 8'h11, 1'b0, 1'b1);
    vec[12] = mk(4'b0001, 32'h1100_0022, 4'b0000, 8'h11, 1'b0, 1'b0);
    vec[13] = mk(4'b1001, 32'h1100_0022, 4'b0001, 8'h11, 1'b0, 1'b1);
    vec[14] = mk(4'b1001, 32'h1100_0022, 4'b0001, 8'h22, 1'b1, 1'b1);
    vec[15] = mk(4'b1000, 32'h1100_0022, 4'b0000, 8'h22, 1'b0, 1'b1);
    vec[16] = mk(4'b1000, 32'h1100_0022, 4'b0000, 8'h22, 1'b0, 1'b0);
    vec[17] = mk(4'b0110, 32'h0077_5A00, 4'b0010, 8'h22, 1'b0, 1'b1);
    vec[18] = mk(4'b0110, 32'h0077_5A00, 4'b0010, 8'h5A, 1'b1, 1'b1);
    vec[19] = mk(4'b0110, 32'h0077_6B00, 4'b0010, 8'h6B, 1'b1, 1'b1);
    vec[20] = mk(4'b0100, 32'h0077_7C00, 4'b0000, 8'h6B, 1'b0, 1'b1);
    vec[21] = mk(4'b1001, 32'h0077_7C00, 4'b0000, 8'h6B, 1'b0, 1'b0);
    vec[22] = mk(4'b1001, 32'h9977_7C00, 4'b1000, 8'h6B, 1'b0, 1'b1);
    vec[23] = mk(4'b1001, 32'h9977_7C00, 4'b1000, 8'h99, 1'b1, 1'b1);
    vec[24] = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h99, 1'b0, 1'b1);
    vec[25] = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h99, 1'b0, 1'b0);
    vec[26] = mk(4'b0100, 32'h00EE_0000, 4'b0100, 8'h99, 1'b0, 1'b1);
    vec[27] = mk(4'b0000, 32'h00EE_0000, 4'b0000, 8'h99, 1'b0, 1'b1);
    vec[28] = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h99, 1'b0, 1'b0);
    vec[29] = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'h99, 1'b0, 1'b0);

    // Reset held with random inputs
    rst_n   = 1'b0;
    req     = 4'($urandom);
    data_in = $urandom;
    @(negedge clk);
    tick();
    check("reset grant", 32'(grant), 32'h0);
    check("reset q", 32'(q), 32'h00);
    check("reset q_valid", 32'(q_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      req     = vec[i].req;
      data_in = vec[i].data;
      tick();
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vec[i].grant));
      check($sformatf("v%0d q", i), 32'(q), 32'(vec[i].q));
      check($sformatf("v%0d q_valid", i), 32'(q_valid), 32'(vec[i].qv));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vec[i].busy));
    end

    // Async reset in the middle of a grant; ptr is 3 at this point
    req     = 4'b0100;
    data_in = 32'h00C3_0000;
    tick();
    check("mid grant", 32'(grant), 32'h4);
    tick();
    check("mid load q", 32'(q), 32'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("async grant", 32'(grant), 32'h0);
    check("async q", 32'(q), 32'h00);
    check("async q_valid", 32'(q_valid), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    check("post reset grant", 32'(grant), 32'h2);
    check("post reset busy", 32'(busy), 32'h1);
    check("post reset q", 32'(q), 32'h00);

    // Everyone requesting from a fresh reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    req     = 4'b1111;
    data_in = 32'h4433_2211;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
`ifdef RR_BURST_LIMIT_EN
    for (int n = 1; n <= 35; n++) begin
      tick();
      e    = n - 1;
      slot = e / 7;
      pos  = e % 7;
      exp_g = (pos < 5) ? (4'b0001 << (slot % 4)) : 4'b0000;
      check($sformatf("fair grant c%0d", n), 32'(grant), 32'(exp_g));
      check($sformatf("fair q_valid c%0d", n), 32'(q_valid), 32'((pos >= 1) && (pos <= 4)));
      if ((pos >= 1) && (pos <= 4)) begin
        check($sformatf("fair q c%0d", n), 32'(q), 32'(bytes[slot % 4]));
      end
    end
`else
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_q = (n >= 2) ? bytes[0] : 8'h00;
      check($sformatf("hold grant c%0d", n), 32'(grant), 32'h1);
      check($sformatf("hold q c%0d", n), 32'(q), 32'(exp_q));
      check($sformatf("hold q_valid c%0d", n), 32'(q_valid), 32'(n >= 2));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
